// File: rtl/detect_alert_ctrl.sv
// Alert sequencer: qualifies CONSEC_N consecutive active results, plays a timed piezo tone,
// then holds off before re-arming. Define DETECT_ALERT_VAD_GATE_EN to also require vad=1.
module detect_alert_ctrl #(
  parameter int CONSEC_N       = 2,
  parameter int BEEP_CYCLES    = 50000000,
  parameter int HOLDOFF_CYCLES = 25000000,
  parameter int TONE_HALF      = 6250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       result_dv,
  input  logic       result,
  input  logic       vad,
  output logic       beep,
  output logic       led_active,
  output logic       led_dv,
  output logic       busy,
  output logic [7:0] detect_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BEEP    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam logic [3:0]  STREAK_MAX = 4'(CONSEC_N);
  localparam logic [31:0] BEEP_LAST  = 32'(BEEP_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [31:0] TONE_LAST  = 32'(TONE_HALF - 1);
  localparam bit          SKIP_HOLD  = (HOLDOFF_CYCLES == 0);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] tone_q, tone_d;
  logic        beep_q, beep_d;
  logic        busy_q, busy_d;
  logic        led_active_q, led_active_d;
  logic        led_dv_q, led_dv_d;
  logic [7:0]  count_q, count_d;
  logic        hit_s;

`ifdef DETECT_ALERT_VAD_GATE_EN
  assign hit_s = result & vad;
`else
  logic unused_vad_s;
  assign unused_vad_s = vad;
  assign hit_s        = result;
`endif

  // Next-state logic; LEDs track every strobe regardless of state or enable.
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    timer_d      = timer_q;
    tone_d       = tone_q;
    beep_d       = beep_q;
    count_d      = count_q;
    led_active_d = result_dv ? result : led_active_q;
    led_dv_d     = result_dv ? ~led_dv_q : led_dv_q;

    if (!enable) begin
      state_d  = ST_IDLE;
      streak_d = 4'd0;
      timer_d  = 32'd0;
      tone_d   = 32'd0;
      beep_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_d = 32'd0;
          tone_d  = 32'd0;
          beep_d  = 1'b0;
          if (result_dv && hit_s && (streak_q + 4'd1 >= STREAK_MAX)) begin
            // Streak reached: the tone starts high on the very next cycle.
            state_d  = ST_BEEP;
            streak_d = 4'd0;
            beep_d   = 1'b1;
            count_d  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          end else if (result_dv) begin
            streak_d = hit_s ? streak_q + 4'd1 : 4'd0;
          end else begin
            streak_d = streak_q;
          end
        end
        ST_BEEP: begin
          if (timer_q == BEEP_LAST) begin
            state_d = SKIP_HOLD ? ST_IDLE : ST_HOLDOFF;
            timer_d = 32'd0;
            tone_d  = 32'd0;
            beep_d  = 1'b0;
          end else if (tone_q == TONE_LAST) begin
            timer_d = timer_q + 32'd1;
            tone_d  = 32'd0;
            beep_d  = ~beep_q;
          end else begin
            timer_d = timer_q + 32'd1;
            tone_d  = tone_q + 32'd1;
          end
        end
        ST_HOLDOFF: begin
          beep_d = 1'b0;
          if (timer_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            timer_d = 32'd0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          streak_d = 4'd0;
          timer_d  = 32'd0;
          tone_d   = 32'd0;
          beep_d   = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      streak_q     <= 4'd0;
      timer_q      <= 32'd0;
      tone_q       <= 32'd0;
      beep_q       <= 1'b0;
      busy_q       <= 1'b0;
      led_active_q <= 1'b0;
      led_dv_q     <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      timer_q      <= timer_d;
      tone_q       <= tone_d;
      beep_q       <= beep_d;
      busy_q       <= busy_d;
      led_active_q <= led_active_d;
      led_dv_q     <= led_dv_d;
      count_q      <= count_d;
    end
  end

  assign beep         = beep_q;
  assign busy         = busy_q;
  assign led_active   = led_active_q;
  assign led_dv       = led_dv_q;
  assign detect_count = count_q;

endmodule
